// File: rtl/axi_sram_slave.sv
// AXI3 single-port SRAM slave, one transaction at a time, R/W arbitrated.
// Optional AXI_RAND_STALL_EN: LFSR-driven random back-pressure on all channels.
module axi_sram_slave #(
  parameter int    ADDR_W    = 18,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_RESP, WR_DATA, WR_RESP
  } state_t;

  state_t state, state_n;

  logic [31:0]       mem [DEPTH];
  logic [3:0]        id_q, len_q, cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-3:0] word;
  logic              fixed_q, err_q, lasterr;
  logic              prio;
  logic              grant_rd, grant_wr;
  logic              last_beat, stall;
  logic              r_held, b_held;
  logic              unused_ok;

  assign word      = addr_q[ADDR_W-1:2];
  assign last_beat = (cnt == len_q);
  assign unused_ok = ^{araddr[31:ADDR_W], awaddr[31:ADDR_W],
                       arlen[7:4], awlen[7:4], arlock, arcache,
                       arprot, awlock, awcache, awprot, wid,
                       addr_q[1:0]};

`ifdef AXI_RAND_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0],
                        lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // prio=0 favours reads, prio=1 favours writes
  always_comb begin
    grant_rd = arvalid & (~awvalid | ~prio);
    grant_wr = awvalid & ~grant_rd;
    arready  = 1'b0;
    awready  = 1'b0;
    wready   = 1'b0;
    rvalid   = 1'b0;
    bvalid   = 1'b0;
    state_n  = state;
    unique case (state)
      IDLE: begin
        arready = grant_rd & ~stall;
        awready = grant_wr & ~stall;
        if (arready)      state_n = RD_ISSUE;
        else if (awready) state_n = WR_DATA;
      end
      RD_ISSUE: state_n = RD_RESP;
      RD_RESP: begin
        rvalid = r_held | ~stall;
        if (rvalid && rready)
          state_n = rlast ? IDLE : RD_ISSUE;
      end
      WR_DATA: begin
        wready = ~stall;
        if (wvalid && wready && last_beat)
          state_n = WR_RESP;
      end
      WR_RESP: begin
        bvalid = b_held | ~stall;
        if (bvalid && bready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      id_q    <= '0;
      len_q   <= '0;
      cnt     <= '0;
      addr_q  <= '0;
      fixed_q <= 1'b0;
      err_q   <= 1'b0;
      lasterr <= 1'b0;
      prio    <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= '0;
      rlast   <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
      r_held  <= 1'b0;
      b_held  <= 1'b0;
    end else begin
      state  <= state_n;
      r_held <= rvalid & ~rready;
      b_held <= bvalid & ~bready;
      if (arready) begin
        id_q    <= arid;
        addr_q  <= araddr[ADDR_W-1:0];
        len_q   <= arlen[3:0];
        fixed_q <= (arburst == 2'b00);
        err_q   <= (arsize > 3'd2);
        cnt     <= '0;
        prio    <= ~prio;
      end else if (awready) begin
        id_q    <= awid;
        addr_q  <= awaddr[ADDR_W-1:0];
        len_q   <= awlen[3:0];
        fixed_q <= (awburst == 2'b00);
        err_q   <= (awsize > 3'd2);
        cnt     <= '0;
        lasterr <= 1'b0;
        prio    <= ~prio;
      end
      if (state == RD_ISSUE) begin
        rid   <= id_q;
        rdata <= err_q ? 32'h0 : mem[word];
        rresp <= err_q ? 2'b10 : 2'b00;
        rlast <= last_beat;
      end
      if (rvalid && rready && !rlast) begin
        cnt <= cnt + 4'd1;
        if (!fixed_q) addr_q <= addr_q + ADDR_W'(4);
      end
      if (wvalid && wready) begin
        cnt <= cnt + 4'd1;
        if (!fixed_q) addr_q <= addr_q + ADDR_W'(4);
        if (wlast != last_beat) lasterr <= 1'b1;
        if (last_beat) begin
          bid   <= id_q;
          bresp <= (err_q | lasterr | (wlast != last_beat))
                   ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (wvalid && wready && !err_q) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[word][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule
